// File: rtl/nearest_pkg.sv
// Shared types and default widths for the nearest-value search stage.
package nearest_pkg;

  localparam int W     = 8;
  localparam int CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/nearest_select.sv
// Combinational closer-to-reference compare: candidate distance and a strict-improvement flag.
module nearest_select #(
  parameter int W = 8
) (
  input  logic [W-1:0] ref_val,
  input  logic [W-1:0] incumbent,
  input  logic [W-1:0] candidate,
  output logic [W-1:0] cand_dist,
  output logic         take
);

  logic [W-1:0] inc_dist;

  // Plain unsigned distance, ordered so the subtraction never wraps.
  always_comb begin
    cand_dist = (candidate >= ref_val) ? (candidate - ref_val) : (ref_val - candidate);
    inc_dist  = (incumbent >= ref_val) ? (incumbent - ref_val) : (ref_val - incumbent);
    take      = cand_dist < inc_dist;
  end

endmodule

// File: rtl/nearest_value_tracker.sv
// Streams candidates over valid/ready and keeps the one closest to a latched reference.
module nearest_value_tracker #(
  parameter int W     = nearest_pkg::W,
  parameter int CNT_W = nearest_pkg::CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [W-1:0]     ref_in,
  input  logic             cand_valid,
  input  logic [W-1:0]     cand_data,
  input  logic             cand_last,
  output logic             cand_ready,
  output logic             busy,
  output logic             done,
  output logic [W-1:0]     best_data,
  output logic [W-1:0]     best_dist,
  output logic [CNT_W-1:0] best_index,
  output logic [CNT_W-1:0] count
);

  import nearest_pkg::*;

  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  state_t           state_q, state_d;
  logic [W-1:0]     ref_q, ref_d;
  logic [W-1:0]     best_data_q, best_data_d;
  logic [W-1:0]     best_dist_q, best_dist_d;
  logic [CNT_W-1:0] best_index_q, best_index_d;
  logic [CNT_W-1:0] count_q, count_d;

  logic [W-1:0] cand_dist;
  logic         take;
  logic         accept;

  nearest_select #(.W(W)) u_select (
    .ref_val   (ref_q),
    .incumbent (best_data_q),
    .candidate (cand_data),
    .cand_dist (cand_dist),
    .take      (take)
  );

  assign cand_ready = (state_q == SCAN);
  assign busy       = (state_q == SCAN) || (state_q == DONE);
  assign done       = (state_q == DONE);
  assign accept     = cand_valid && cand_ready;

  always_comb begin
    state_d      = state_q;
    ref_d        = ref_q;
    best_data_d  = best_data_q;
    best_dist_d  = best_dist_q;
    best_index_d = best_index_q;
    count_d      = count_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          state_d      = SCAN;
          ref_d        = ref_in;
          best_data_d  = '0;
          best_dist_d  = '0;
          best_index_d = '0;
          count_d      = '0;
        end
      end
      SCAN: begin
        if (accept) begin
          // Strict compare keeps the incumbent on a tie, so the earliest index wins.
          if ((count_q == '0) || take) begin
            best_data_d  = cand_data;
            best_dist_d  = cand_dist;
            best_index_d = count_q;
          end
          count_d = count_q + CNT_W'(1);
          if (cand_last || (count_q == MAX_CNT - CNT_W'(1))) begin
            state_d = DONE;
          end
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      ref_q        <= '0;
      best_data_q  <= '0;
      best_dist_q  <= '0;
      best_index_q <= '0;
      count_q      <= '0;
    end else begin
      state_q      <= state_d;
      ref_q        <= ref_d;
      best_data_q  <= best_data_d;
      best_dist_q  <= best_dist_d;
      best_index_q <= best_index_d;
      count_q      <= count_d;
    end
  end

  assign best_data  = best_data_q;
  assign best_dist  = best_dist_q;
  assign best_index = best_index_q;
  assign count      = count_q;

endmodule

// File: tb/tb_nearest_value_tracker.sv
// Directed bench for nearest_value_tracker: default-width instance plus a CNT_W=2 instance for the cap case.
module tb_nearest_value_tracker;

  logic       clk;
  logic       rst;

  logic       start, cand_valid, cand_last;
  logic [7:0] ref_in, cand_data;
  logic       cand_ready, busy, done;
  logic [7:0] best_data, best_dist;
  logic [3:0] best_index, count;

  logic       c_start, c_valid, c_last;
  logic [7:0] c_ref, c_data;
  logic       c_ready, c_busy, c_done;
  logic [7:0] c_best_data, c_best_dist;
  logic [1:0] c_best_index, c_count;

  int checks = 0;
  int errors = 0;

  nearest_value_tracker #(.W(8), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .start(start), .ref_in(ref_in),
    .cand_valid(cand_valid), .cand_data(cand_data), .cand_last(cand_last),
    .cand_ready(cand_ready), .busy(busy), .done(done),
    .best_data(best_data), .best_dist(best_dist),
    .best_index(best_index), .count(count)
  );

  nearest_value_tracker #(.W(8), .CNT_W(2)) cap_dut (
    .clk(clk), .rst(rst), .start(c_start), .ref_in(c_ref),
    .cand_valid(c_valid), .cand_data(c_data), .cand_last(c_last),
    .cand_ready(c_ready), .busy(c_busy), .done(c_done),
    .best_data(c_best_data), .best_dist(c_best_dist),
    .best_index(c_best_index), .count(c_count)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Inputs change on the falling edge; outputs are sampled on the falling edge too.
  task automatic applyStimulus(input string tag, input logic [7:0] refv, input int n,
                               input logic [7:0] c0, input logic [7:0] c1,
                               input logic [7:0] c2, input logic [7:0] c3,
                               input logic [7:0] exp_data, input logic [7:0] exp_dist,
                               input logic [3:0] exp_index);
    logic [7:0] cands [4];
    cands[0] = c0; cands[1] = c1; cands[2] = c2; cands[3] = c3;
    start  = 1'b1;
    ref_in = refv;
    @(negedge clk);
    start = 1'b0;
    checkOutput({tag, "_ready"}, 32'(cand_ready), 1);
    for (int i = 0; i < n; i++) begin
      cand_valid = 1'b1;
      cand_data  = cands[i];
      cand_last  = (i == n - 1);
      @(negedge clk);
    end
    cand_valid = 1'b0;
    cand_last  = 1'b0;
    checkOutput({tag, "_done"},  32'(done), 1);
    checkOutput({tag, "_data"},  32'(best_data), 32'(exp_data));
    checkOutput({tag, "_dist"},  32'(best_dist), 32'(exp_dist));
    checkOutput({tag, "_index"}, 32'(best_index), 32'(exp_index));
    checkOutput({tag, "_count"}, 32'(count), n);
    @(negedge clk);
    checkOutput({tag, "_done_drop"}, 32'(done), 0);
    checkOutput({tag, "_idle"}, 32'(busy), 0);
    checkOutput({tag, "_hold"}, 32'(best_data), 32'(exp_data));
  endtask

  initial begin
    rst = 1'b1;
    start = 1'b0; cand_valid = 1'b0; cand_last = 1'b0; ref_in = '0; cand_data = '0;
    c_start = 1'b0; c_valid = 1'b0; c_last = 1'b0; c_ref = '0; c_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_ready", 32'(cand_ready), 0);
    checkOutput("rst_busy",  32'(busy), 0);
    checkOutput("rst_done",  32'(done), 0);
    checkOutput("rst_data",  32'(best_data), 0);
    checkOutput("rst_count", 32'(count), 0);
    rst = 1'b0;
    @(negedge clk);

    applyStimulus("basic", 8'h07, 4, 8'h0A, 8'h05, 8'h09, 8'h07, 8'h07, 8'h00, 4'd3);
    applyStimulus("tie",   8'h10, 2, 8'h0E, 8'h12, 8'h00, 8'h00, 8'h0E, 8'h02, 4'd0);
    applyStimulus("nowrap", 8'h00, 1, 8'hFF, 8'h00, 8'h00, 8'h00, 8'hFF, 8'hFF, 4'd0);

    // Cap: three accepts fill a 2-bit counter with last never asserted.
    c_start = 1'b1; c_ref = 8'h40;
    @(negedge clk);
    c_start = 1'b0;
    c_valid = 1'b1;
    c_data = 8'h50; @(negedge clk);
    c_data = 8'h41; @(negedge clk);
    c_data = 8'h30; @(negedge clk);
    checkOutput("cap_done",  32'(c_done), 1);
    checkOutput("cap_ready", 32'(c_ready), 0);
    checkOutput("cap_data",  32'(c_best_data), 'h41);
    checkOutput("cap_index", 32'(c_best_index), 1);
    checkOutput("cap_count", 32'(c_count), 3);
    @(negedge clk);
    checkOutput("cap_ready_idle", 32'(c_ready), 0);
    checkOutput("cap_count_hold", 32'(c_count), 3);
    c_valid = 1'b0;

    // Candidate held valid through IDLE must not be taken before SCAN.
    cand_valid = 1'b1; cand_data = 8'h33;
    @(negedge clk);
    @(negedge clk);
    checkOutput("ign_idle_busy", 32'(busy), 0);
    start = 1'b1; ref_in = 8'h20;
    @(negedge clk);
    checkOutput("ign_idle_count", 32'(count), 0);
    ref_in = 8'h31;
    @(negedge clk);
    start = 1'b0;
    checkOutput("ign_count1", 32'(count), 1);
    checkOutput("ign_reflatch", 32'(best_dist), 'h13);
    cand_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkOutput("gap_count", 32'(count), 1);
    checkOutput("gap_data",  32'(best_data), 'h33);
    checkOutput("gap_busy",  32'(busy), 1);
    cand_valid = 1'b1; cand_data = 8'h22; cand_last = 1'b1;
    @(negedge clk);
    cand_valid = 1'b0; cand_last = 1'b0;
    checkOutput("gap_done",  32'(done), 1);
    checkOutput("gap_best",  32'(best_data), 'h22);
    checkOutput("gap_dist",  32'(best_dist), 'h02);
    checkOutput("gap_index", 32'(best_index), 1);
    @(negedge clk);

    // Reset after two of four candidates, with a third presented alongside it.
    start = 1'b1; ref_in = 8'h07;
    @(negedge clk);
    start = 1'b0;
    cand_valid = 1'b1;
    cand_data = 8'h0A; @(negedge clk);
    cand_data = 8'h05; @(negedge clk);
    cand_data = 8'h09; rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; cand_valid = 1'b0;
    checkOutput("mid_ready", 32'(cand_ready), 0);
    checkOutput("mid_busy",  32'(busy), 0);
    checkOutput("mid_done",  32'(done), 0);
    checkOutput("mid_data",  32'(best_data), 0);
    checkOutput("mid_dist",  32'(best_dist), 0);
    checkOutput("mid_index", 32'(best_index), 0);
    checkOutput("mid_count", 32'(count), 0);
    @(negedge clk);
    checkOutput("mid_nodone", 32'(done), 0);

    applyStimulus("post_rst", 8'h07, 4, 8'h0A, 8'h05, 8'h09, 8'h07, 8'h07, 8'h00, 4'd3);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
